// File: rtl/ram_dual_port_hs_pkg.sv
// Shared definitions for the dual-port handshake RAM.
// Holds default geometry, the column-count helper and the response stage
// record {valid, data} at the default word width.
package ram_dual_port_hs_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_COL_WIDTH  = 8;
  localparam int NUM_COL        = DEF_DATA_WIDTH / DEF_COL_WIDTH;

  typedef struct packed {
    logic                      valid;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rsp_t;

  function automatic int num_col(input int data_width, input int col_width);
    return data_width / col_width;
  endfunction

endpackage

// File: rtl/ram_dual_port_hs_if.sv
// Bus bundle for ram_dual_port_hs.
// Port A: a_valid/a_ready request handshake with byte enables a_we
// (all-zero = read), a_addr, a_din; response a_rvalid/a_rready/a_dout.
// Port B: b_valid/b_addr fetch request (always accepted); response
// b_rvalid/b_dout.
// master = requester side (LSU + fetch unit), slave = the RAM.
interface ram_dual_port_hs_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COL    = 4
);
  logic                  a_valid;
  logic                  a_ready;
  logic [NUM_COL-1:0]    a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic                  a_rvalid;
  logic                  a_rready;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_dout;

  modport master (
    output a_valid, a_we, a_addr, a_din, a_rready, b_valid, b_addr,
    input  a_ready, a_rvalid, a_dout, b_rvalid, b_dout
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_din, a_rready, b_valid, b_addr,
    output a_ready, a_rvalid, a_dout, b_rvalid, b_dout
  );
endinterface

// File: rtl/ram_skid_fifo.sv
// Two-entry FIFO holding port A read responses while the LSU stalls.
// Ports: clk, rst_n (async active-low), push/din, pop/dout (head word),
// empty, count (0..2). Simultaneous push and pop keeps occupancy and order.
// Storage is not reset; only pointers and count are.
module ram_skid_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] slot [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= din;
  end

  assign dout  = slot[rd_ptr];
  assign empty = (cnt == 2'd0);
  assign count = cnt;
endmodule

// File: rtl/ram_dual_port_hs.sv
// Instruction/data RAM with valid/ready handshakes.
// Port A (LSU): byte-masked read/write, READ_LATENCY read responses routed
// through a 2-entry skid FIFO so a_dout/a_rvalid hold until a_rready.
// Port B (fetch): read-only, always ready, READ_LATENCY responses.
// Both ports share one array; a same-cycle A write is merged into a B read
// of the same address so fetches see the new bytes.
// Ports: clk, rst_n (async active-low), bus (ram_dual_port_hs_if.slave).
// The array itself is never reset.
module ram_dual_port_hs
  import ram_dual_port_hs_pkg::*;
#(
  parameter int    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int    COL_WIDTH    = DEF_COL_WIDTH,
  parameter int    READ_LATENCY = 1,
  parameter string DATA_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_dual_port_hs_if.slave bus
);
  localparam int NCOL  = num_col(DATA_WIDTH, COL_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % COL_WIDTH != 0) begin : g_bad_cols
    $error("DATA_WIDTH must be a multiple of COL_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  // Overlay enabled columns of wdata onto old.
  function automatic logic [DATA_WIDTH-1:0] merge_cols(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [NCOL-1:0]       we
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int c = 0; c < NCOL; c++) begin
      if (we[c]) r[c*COL_WIDTH +: COL_WIDTH] = wdata[c*COL_WIDTH +: COL_WIDTH];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_acc, a_wr, a_rd, a_pop, a_rvalid;
  logic [NCOL-1:0]       b_fwd_we;
  logic [DATA_WIDTH-1:0] b_merged;
  logic                  a_vld_p0, b_vld_p0;
  logic [DATA_WIDTH-1:0] a_data_p0, b_data_p0;
  stage_t                a_out, b_out;
  logic [1:0]            a_inflight;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [2:0]            a_occ;

  assign a_acc = bus.a_valid & bus.a_ready;
  assign a_wr  = a_acc & (|bus.a_we);
  assign a_rd  = a_acc & ~(|bus.a_we);

  // Array write: only enabled columns change.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCOL; c++) begin
      if (a_wr && bus.a_we[c])
        mem[bus.a_addr][c*COL_WIDTH +: COL_WIDTH] <= bus.a_din[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  // B reads the pre-edge array value, so a colliding A write is forwarded.
  assign b_fwd_we = (a_wr && bus.a_addr == bus.b_addr) ? bus.a_we : '0;
  assign b_merged = merge_cols(mem[bus.b_addr], bus.a_din, b_fwd_we);

  // ---- stage p0: array read register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_p0 <= 1'b0;
      b_vld_p0 <= 1'b0;
    end else begin
      a_vld_p0 <= a_rd;
      b_vld_p0 <= bus.b_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (a_rd)        a_data_p0 <= mem[bus.a_addr];
    if (bus.b_valid) b_data_p0 <= b_merged;
  end

  // ---- stage p1: optional output register ----
  if (READ_LATENCY == 2) begin : g_lat2
    logic                  a_vld_p1, b_vld_p1;
    logic [DATA_WIDTH-1:0] a_data_p1, b_data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_vld_p1 <= 1'b0;
        b_vld_p1 <= 1'b0;
      end else begin
        a_vld_p1 <= a_vld_p0;
        b_vld_p1 <= b_vld_p0;
      end
    end

    always_ff @(posedge clk) begin
      a_data_p1 <= a_data_p0;
      b_data_p1 <= b_data_p0;
    end

    assign a_out      = '{valid: a_vld_p1, data: a_data_p1};
    assign b_out      = '{valid: b_vld_p1, data: b_data_p1};
    assign a_inflight = 2'(a_vld_p0) + 2'(a_vld_p1);
  end else begin : g_lat1
    assign a_out      = '{valid: a_vld_p0, data: a_data_p0};
    assign b_out      = '{valid: b_vld_p0, data: b_data_p0};
    assign a_inflight = 2'(a_vld_p0);
  end

  // ---- response stage: skid FIFO with flow-through ----
  // The pipeline output bypasses the FIFO only when the FIFO is empty and
  // the LSU takes it this cycle; otherwise it queues behind older entries.
  assign a_rvalid  = ~fifo_empty | a_out.valid;
  assign a_pop     = a_rvalid & bus.a_rready;
  assign fifo_push = a_out.valid & ~(fifo_empty & bus.a_rready);
  assign fifo_pop  = a_pop & ~fifo_empty;

  ram_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (a_out.data),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Every accepted read reserves a FIFO slot; a response leaving this cycle
  // frees one. Writes wait on the same credit so A traffic stays in order.
  assign a_occ       = 3'(fifo_cnt) + 3'(a_inflight);
  assign bus.a_ready = (a_occ - 3'(a_pop)) < 3'd2;

  assign bus.a_rvalid = a_rvalid;
  assign bus.a_dout   = !fifo_empty ? fifo_head : (a_out.valid ? a_out.data : '0);
  assign bus.b_rvalid = b_out.valid;
  assign bus.b_dout   = b_out.valid ? b_out.data : '0;
endmodule

// File: tb/tb_ram_dual_port_hs.sv
module tb_ram_dual_port_hs;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ram_dual_port_hs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_COL(4)) bus1 ();
  ram_dual_port_hs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_COL(4)) bus2 ();

  ram_dual_port_hs #(.READ_LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ram_dual_port_hs #(.READ_LATENCY(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a1_req(input logic [11:0] addr, input logic [3:0] we, input logic [31:0] din);
    bit done;
    done = 1'b0;
    bus1.a_valid = 1'b1; bus1.a_we = we; bus1.a_addr = addr; bus1.a_din = din;
    for (int i = 0; i < 20 && !done; i++) begin
      #3;
      done = bus1.a_ready;
      @(posedge clk);
      #1;
    end
    bus1.a_valid = 1'b0; bus1.a_we = 4'h0;
    if (!done) begin
      n_checks++;
      $display("FAIL a1_accept_timeout addr=%h: accepted=0 required=1", addr);
    end
  endtask

  task automatic a2_req(input logic [11:0] addr, input logic [3:0] we, input logic [31:0] din);
    bit done;
    done = 1'b0;
    bus2.a_valid = 1'b1; bus2.a_we = we; bus2.a_addr = addr; bus2.a_din = din;
    for (int i = 0; i < 20 && !done; i++) begin
      #3;
      done = bus2.a_ready;
      @(posedge clk);
      #1;
    end
    bus2.a_valid = 1'b0; bus2.a_we = 4'h0;
    if (!done) begin
      n_checks++;
      $display("FAIL a2_accept_timeout addr=%h: accepted=0 required=1", addr);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus1.a_rvalid !== 1'b0) $display("FAIL rst_a_rvalid: got %b want 0", bus1.a_rvalid); else n_pass++;
    n_checks++; if (bus1.b_rvalid !== 1'b0) $display("FAIL rst_b_rvalid: got %b want 0", bus1.b_rvalid); else n_pass++;
    n_checks++; if (bus1.a_dout !== 32'h0) $display("FAIL rst_a_dout: got %h want 0", bus1.a_dout); else n_pass++;
    n_checks++; if (bus1.b_dout !== 32'h0) $display("FAIL rst_b_dout: got %h want 0", bus1.b_dout); else n_pass++;
    n_checks++; if (bus2.a_rvalid !== 1'b0) $display("FAIL rst_a_rvalid_l2: got %b want 0", bus2.a_rvalid); else n_pass++;
    n_checks++; if (bus1.a_ready !== 1'b1) $display("FAIL rst_a_ready: got %b want 1", bus1.a_ready); else n_pass++;
  endtask

  task automatic test_write_read();
    bus1.a_rready = 1'b1;
    a1_req(12'h010, 4'hF, 32'hDEADBEEF);
    a1_req(12'h010, 4'h0, 32'h0);
    n_checks++; if (bus1.a_rvalid !== 1'b1) $display("FAIL wr_rd_rvalid: got %b want 1", bus1.a_rvalid); else n_pass++;
    n_checks++; if (bus1.a_dout !== 32'hDEADBEEF) $display("FAIL wr_rd_dout: got %h want deadbeef", bus1.a_dout); else n_pass++;
    step();
    n_checks++; if (bus1.a_rvalid !== 1'b0) $display("FAIL wr_rd_consumed: got %b want 0", bus1.a_rvalid); else n_pass++;
  endtask

  task automatic test_partial_write();
    a1_req(12'h011, 4'hF, 32'h11223344);
    a1_req(12'h011, 4'b0010, 32'h0000AA00);
    a1_req(12'h011, 4'h0, 32'h0);
    n_checks++; if (bus1.a_dout !== 32'h1122AA44 || bus1.a_rvalid !== 1'b1)
      $display("FAIL partial_dout: got %h (v=%b) want 1122aa44", bus1.a_dout, bus1.a_rvalid); else n_pass++;
    step();
  endtask

  task automatic test_coherence();
    bus1.a_valid = 1'b1; bus1.a_we = 4'hF; bus1.a_addr = 12'h020; bus1.a_din = 32'hCAFEF00D;
    bus1.b_valid = 1'b1; bus1.b_addr = 12'h020;
    step();
    bus1.a_we = 4'b0001; bus1.a_din = 32'h000000EE;
    n_checks++; if (bus1.b_rvalid !== 1'b1 || bus1.b_dout !== 32'hCAFEF00D)
      $display("FAIL coh_full: got %h (v=%b) want cafef00d", bus1.b_dout, bus1.b_rvalid); else n_pass++;
    step();
    bus1.a_valid = 1'b0; bus1.a_we = 4'h0;
    n_checks++; if (bus1.b_dout !== 32'hCAFEF0EE)
      $display("FAIL coh_partial: got %h want cafef0ee", bus1.b_dout); else n_pass++;
    step();
    bus1.b_valid = 1'b0;
    n_checks++; if (bus1.b_dout !== 32'hCAFEF0EE)
      $display("FAIL coh_committed: got %h want cafef0ee", bus1.b_dout); else n_pass++;
    step();
    n_checks++; if (bus1.b_rvalid !== 1'b0) $display("FAIL coh_b_idle: got %b want 0", bus1.b_rvalid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int issued;
    int got;
    bit acc;
    bit rsp;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) a1_req(12'h030 + 12'(i), 4'hF, 32'h0BAD0000 + 32'(i));
    issued = 0;
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      bus1.a_valid  = (issued < 4);
      bus1.a_we     = 4'h0;
      bus1.a_addr   = 12'h030 + issued[11:0];
      bus1.a_rready = (k >= 6);
      #3;
      acc = bus1.a_valid & bus1.a_ready;
      rsp = bus1.a_rvalid & bus1.a_rready;
      d   = bus1.a_dout;
      if (k == 5) begin
        n_checks++; if (bus1.a_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", bus1.a_ready); else n_pass++;
        n_checks++; if (issued != 2) $display("FAIL bp_outstanding: got %0d want 2", issued); else n_pass++;
        n_checks++; if (bus1.a_rvalid !== 1'b1 || d !== 32'h0BAD0000)
          $display("FAIL bp_hold: got %h (v=%b) want 0bad0000", d, bus1.a_rvalid); else n_pass++;
      end
      if (rsp) begin
        n_checks++; if (d !== 32'h0BAD0000 + 32'(got))
          $display("FAIL bp_order%0d: got %h want %h", got, d, 32'h0BAD0000 + 32'(got)); else n_pass++;
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) issued++;
    end
    bus1.a_valid = 1'b0;
    n_checks++; if (got != 4) $display("FAIL bp_count: got %0d want 4", got); else n_pass++;
    n_checks++; if (bus1.a_rvalid !== 1'b0) $display("FAIL bp_drained: got %b want 0", bus1.a_rvalid); else n_pass++;
  endtask

  task automatic test_reset_midread();
    a1_req(12'h040, 4'hF, 32'h55AA1234);
    bus1.a_rready = 1'b0;
    a1_req(12'h040, 4'h0, 32'h0);
    n_checks++; if (bus1.a_rvalid !== 1'b1) $display("FAIL mr_pending: got %b want 1", bus1.a_rvalid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus1.a_rvalid !== 1'b0) $display("FAIL mr_rvalid_async: got %b want 0", bus1.a_rvalid); else n_pass++;
    n_checks++; if (bus1.a_dout !== 32'h0) $display("FAIL mr_dout_async: got %h want 0", bus1.a_dout); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus1.a_rready = 1'b1;
    n_checks++; if (bus1.a_rvalid !== 1'b0) $display("FAIL mr_dropped: got %b want 0", bus1.a_rvalid); else n_pass++;
    a1_req(12'h040, 4'h0, 32'h0);
    n_checks++; if (bus1.a_dout !== 32'h55AA1234) $display("FAIL mr_keep40: got %h want 55aa1234", bus1.a_dout); else n_pass++;
    step();
    a1_req(12'h010, 4'h0, 32'h0);
    n_checks++; if (bus1.a_dout !== 32'hDEADBEEF) $display("FAIL mr_keep10: got %h want deadbeef", bus1.a_dout); else n_pass++;
    step();
  endtask

  task automatic test_latency2();
    logic [31:0] exp_w [8];
    exp_w = '{32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333,
              32'hA4444444, 32'hA5555555, 32'hA6666666, 32'hA7777777};
    bus2.a_rready = 1'b1;
    for (int i = 0; i < 8; i++) a2_req(12'(i), 4'hF, exp_w[i]);
    a2_req(12'h003, 4'h0, 32'h0);
    n_checks++; if (bus2.a_rvalid !== 1'b0) $display("FAIL l2_a_early: got %b want 0", bus2.a_rvalid); else n_pass++;
    step();
    n_checks++; if (bus2.a_rvalid !== 1'b1 || bus2.a_dout !== 32'hA3333333)
      $display("FAIL l2_a_read: got %h (v=%b) want a3333333", bus2.a_dout, bus2.a_rvalid); else n_pass++;
    step();
    for (int k = 0; k < 11; k++) begin
      bus2.b_valid = (k < 8);
      bus2.b_addr  = 12'(k);
      #3;
      n_checks++; if (bus2.b_rvalid !== ((k >= 2 && k < 10) ? 1'b1 : 1'b0))
        $display("FAIL l2_b_rvalid_c%0d: got %b want %b", k, bus2.b_rvalid, (k >= 2 && k < 10)); else n_pass++;
      if (k >= 2 && k < 10) begin
        n_checks++; if (bus2.b_dout !== exp_w[k-2])
          $display("FAIL l2_b_dout_c%0d: got %h want %h", k, bus2.b_dout, exp_w[k-2]); else n_pass++;
      end
      @(posedge clk);
      #1;
    end
    bus2.b_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus1.a_valid = 1'b0; bus1.a_we = 4'h0; bus1.a_addr = '0; bus1.a_din = '0;
    bus1.a_rready = 1'b1; bus1.b_valid = 1'b0; bus1.b_addr = '0;
    bus2.a_valid = 1'b0; bus2.a_we = 4'h0; bus2.a_addr = '0; bus2.a_din = '0;
    bus2.a_rready = 1'b1; bus2.b_valid = 1'b0; bus2.b_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_write_read();
    test_partial_write();
    test_coherence();
    test_backpressure();
    test_reset_midread();
    test_latency2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
